instr_load_buffer: RTL and testbench
====================================

// Module: instr_load_buffer
// PURPOSE
//   Parametrised instruction store for the pipelined CPU: serially loads a program word-per-clock while
//   LoadInstructions is high, then serves IF-stage fetches with 1-cycle latency. Generalises the fixed
//   32-bit loader with width/depth parameters, a reset-retention mode, program-length tracking, and
//   end-of-program NOP padding. It also flags overflow and stalls fetches during a load. Sits between the
//   testbench/host load port and the IF stage.
// PARAMETERS
//   DATA_W            32      instruction width in bits
//   DEPTH             64      number of instruction words stored
//   ADDR_W            $clog2(DEPTH)  word-index width (derived)
//   NOP_WORD          32'h0   word returned for out-of-program / stalled fetches (DATA_W wide)
//   PRESERVE_ON_RESET 1       1: memory and prog_len survive Reset; 0: prog_len cleared by Reset
// PORTS
//   clk               in   1         rising-edge clock
//   Reset             in   1         asynchronous, active-low reset
//   LoadInstructions  in   1         high = load mode; Instruction written each cycle
//   Instruction       in   DATA_W    word to store at the current write pointer
//   fetch_en          in   1         fetch request from IF stage
//   fetch_addr        in   ADDR_W    word index; the caller supplies PC>>2
//   fetch_data        out  DATA_W    fetched word, registered
//   fetch_valid       out  1         fetch_data is a real request response (not a stall bubble)
//   past_end          out  1         the last fetch addressed >= prog_len; NOP_WORD returned
//   prog_len          out  ADDR_W+1  number of words in the current program
//   loading           out  1         FSM in LOAD
//   full              out  1         write pointer == DEPTH
//   overflow          out  1         sticky: a load word was dropped because the store was full
// BEHAVIOUR
//   Reset (Reset==0, async): FSM->IDLE, wr_ptr=0, fetch_data=NOP_WORD, fetch_valid=0, past_end=0,
//     loading=0, full=0, overflow=0. Memory array is never reset.
//     prog_len: retained if PRESERVE_ON_RESET=1 (X after power-up until the first load completes);
//     0 if PRESERVE_ON_RESET=0.
//   FSM states: IDLE, LOAD, RUN.
//     IDLE/RUN -> LOAD when LoadInstructions==1 at a clk edge. On entry: wr_ptr=0, overflow=0, full=0.
//       The first word is written on the same edge.
//     LOAD: each edge with LoadInstructions==1 and wr_ptr<DEPTH: mem[wr_ptr]<=Instruction, wr_ptr++.
//       If wr_ptr==DEPTH: word dropped, overflow<=1, wr_ptr holds (no wrap-around).
//     LOAD -> RUN on the first edge with LoadInstructions==0; prog_len<=wr_ptr on that edge.
//     RUN stays until the next load. IDLE serves fetches using the retained prog_len.
//   Fetch (IDLE/RUN, fetch_en==1): on the next edge fetch_valid<=1.
//     If fetch_addr<prog_len: fetch_data<=mem[fetch_addr], past_end<=0.
//     Else: fetch_data<=NOP_WORD, past_end<=1.
//   fetch_en==0: fetch_valid<=0; fetch_data and past_end hold.
//   Load/fetch collision: load has priority. While in LOAD, or on the edge entering LOAD, a fetch gives
//     fetch_valid<=0 and fetch_data<=NOP_WORD.
//   Reset mid-load: FSM->IDLE, wr_ptr=0. Words already written stay in memory. prog_len is not updated
//     by the aborted load (old value if PRESERVE_ON_RESET=1).
//   Latency: load write 0 cycles (visible to a fetch issued the cycle after RUN is entered); fetch 1 cycle.
//   Width: prog_len is ADDR_W+1 bits so that DEPTH itself is representable; compares are unsigned.
// TESTING
//   1 Load 10 words, first 0x200101A7 (addi $R1,$0,423); drop LoadInstructions; fetch addr 0
//     -> next cycle fetch_data=0x200101A7, fetch_valid=1, prog_len=10.
//   2 After test 1, fetch addr 9 -> SW word (0xAC070000); fetch addr 10 -> fetch_data=0, past_end=1.
//   3 DEPTH=4: load 6 words -> full=1 after the 4th, overflow=1, prog_len=4; mem[0..3] = first 4 words.
//   4 PRESERVE_ON_RESET=1: load 10, pulse Reset low 1 cycle -> prog_len=10, fetch 5 returns word 5.
//     With =0 -> prog_len=0, every fetch past_end=1.
//   5 Assert Reset during the 3rd word of a 10-word reload -> loading=0, wr_ptr=0, prog_len unchanged.
//   6 fetch_en high on the cycle LoadInstructions rises -> fetch_valid=0, fetch_data=NOP_WORD.
//     A reload of 2 words then gives prog_len=2.

Source files
------------

// File: rtl/instr_load_buffer.sv
// instr_load_buffer
//   Instruction store sitting between the host load port and the IF stage.
//   A program is streamed in one word per clock while LoadInstructions is
//   high; afterwards the IF stage fetches words with one cycle of latency.
//   Fetches beyond the loaded program return NOP_WORD and raise past_end.
//   Loading always wins over fetching: a fetch issued while a load is in
//   progress (or on the edge that starts one) yields a NOP bubble.
//
// Ports
//   clk              rising-edge clock
//   Reset            asynchronous, active-low reset
//   LoadInstructions high = load mode, Instruction written each cycle
//   Instruction      word stored at the current write pointer
//   fetch_en         fetch request from the IF stage
//   fetch_addr       word index (PC>>2)
//   fetch_data       fetched word, registered
//   fetch_valid      fetch_data answers a real request (not a stall bubble)
//   past_end         last fetch addressed at or beyond prog_len
//   prog_len         number of words in the current program
//   loading          FSM is in LOAD
//   full             write pointer reached DEPTH
//   overflow         sticky: a load word was dropped because the store was full
module instr_load_buffer #(
  parameter int                DATA_W            = 32,
  parameter int                DEPTH             = 64,
  parameter logic [DATA_W-1:0] NOP_WORD          = '0,
  parameter bit                PRESERVE_ON_RESET = 1'b1,
  localparam int               ADDR_W            = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              LoadInstructions,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              past_end,
  output logic [ADDR_W:0]   prog_len,
  output logic              loading,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_VAL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_reg;
  logic [ADDR_W:0]   prog_len_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] fetch_data_reg;
  logic              fetch_valid_reg;
  logic              past_end_reg;

  logic              load_entry;  // edge that enters LOAD (first word written here)
  logic              load_busy;   // fetches must be stalled on this edge
  logic              load_done;   // edge that leaves LOAD and commits prog_len
  logic              room;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              in_prog;

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RUN: if (LoadInstructions)  state_next = LOAD;
      LOAD:      if (!LoadInstructions) state_next = RUN;
      default:   state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    loading    = (state_reg == LOAD);
    load_entry = (state_reg != LOAD) && LoadInstructions;
    load_busy  = (state_reg == LOAD) || LoadInstructions;
    load_done  = (state_reg == LOAD) && !LoadInstructions;
    room       = (wr_ptr_reg < DEPTH_VAL);
    wr_en      = load_entry || ((state_reg == LOAD) && LoadInstructions && room);
    // On the entry edge the pointer still holds the previous program's length,
    // so the first word always goes to index 0.
    wr_addr    = load_entry ? '0 : wr_ptr_reg[ADDR_W-1:0];
    in_prog    = ({1'b0, fetch_addr} < prog_len_reg);
  end

  // Instruction memory: never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= Instruction;
  end

  // Write pointer, overflow flag and registered fetch port
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg      <= '0;
      overflow_reg    <= 1'b0;
      fetch_data_reg  <= NOP_WORD;
      fetch_valid_reg <= 1'b0;
      past_end_reg    <= 1'b0;
    end else begin
      if (load_entry) begin
        wr_ptr_reg   <= PTR_ONE;
        overflow_reg <= 1'b0;
      end else if ((state_reg == LOAD) && LoadInstructions) begin
        // Pointer saturates at DEPTH; extra words are dropped, not wrapped.
        if (room) wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
        else      overflow_reg <= 1'b1;
      end

      if (fetch_en) begin
        if (load_busy) begin
          fetch_valid_reg <= 1'b0;
          fetch_data_reg  <= NOP_WORD;
        end else begin
          fetch_valid_reg <= 1'b1;
          if (in_prog) begin
            fetch_data_reg <= mem[fetch_addr];
            past_end_reg   <= 1'b0;
          end else begin
            fetch_data_reg <= NOP_WORD;
            past_end_reg   <= 1'b1;
          end
        end
      end else begin
        fetch_valid_reg <= 1'b0;
      end
    end
  end

  // Program length: either survives Reset alongside the memory, or is cleared.
  // An aborted load never commits because Reset forces the FSM out of LOAD.
  generate
    if (PRESERVE_ON_RESET) begin : g_keep_len
      always_ff @(posedge clk) begin
        if (load_done) prog_len_reg <= wr_ptr_reg;
      end
    end else begin : g_clear_len
      always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)         prog_len_reg <= '0;
        else if (load_done) prog_len_reg <= wr_ptr_reg;
      end
    end
  endgenerate

  assign fetch_data  = fetch_data_reg;
  assign fetch_valid = fetch_valid_reg;
  assign past_end    = past_end_reg;
  assign prog_len    = prog_len_reg;
  assign full        = (wr_ptr_reg == DEPTH_VAL);
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_instr_load_buffer.sv
// Directed bench for instr_load_buffer. Three instances share clock and
// reset: a default 64-deep store that retains prog_len over reset, a 4-deep
// store for the overflow case, and a 16-deep store that clears prog_len.
module tb_instr_load_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH 64, preserve on reset
  logic        li_a, fe_a, fv_a, pe_a, ld_a, fu_a, ov_a;
  logic [31:0] ins_a, fd_a;
  logic [5:0]  fa_a;
  logic [6:0]  pl_a;
  // Instance B: DEPTH 4
  logic        li_b, fe_b, fv_b, pe_b, ld_b, fu_b, ov_b;
  logic [31:0] ins_b, fd_b;
  logic [1:0]  fa_b;
  logic [2:0]  pl_b;
  // Instance C: DEPTH 16, prog_len cleared by reset
  logic        li_c, fe_c, fv_c, pe_c, ld_c, fu_c, ov_c;
  logic [31:0] ins_c, fd_c;
  logic [3:0]  fa_c;
  logic [4:0]  pl_c;

  instr_load_buffer #(.DATA_W(32), .DEPTH(64), .PRESERVE_ON_RESET(1'b1)) u_dut_a (
    .clk(clk), .Reset(rst_n), .LoadInstructions(li_a), .Instruction(ins_a),
    .fetch_en(fe_a), .fetch_addr(fa_a), .fetch_data(fd_a), .fetch_valid(fv_a),
    .past_end(pe_a), .prog_len(pl_a), .loading(ld_a), .full(fu_a), .overflow(ov_a));

  instr_load_buffer #(.DATA_W(32), .DEPTH(4), .PRESERVE_ON_RESET(1'b1)) u_dut_b (
    .clk(clk), .Reset(rst_n), .LoadInstructions(li_b), .Instruction(ins_b),
    .fetch_en(fe_b), .fetch_addr(fa_b), .fetch_data(fd_b), .fetch_valid(fv_b),
    .past_end(pe_b), .prog_len(pl_b), .loading(ld_b), .full(fu_b), .overflow(ov_b));

  instr_load_buffer #(.DATA_W(32), .DEPTH(16), .PRESERVE_ON_RESET(1'b0)) u_dut_c (
    .clk(clk), .Reset(rst_n), .LoadInstructions(li_c), .Instruction(ins_c),
    .fetch_en(fe_c), .fetch_addr(fa_c), .fetch_data(fd_c), .fetch_valid(fv_c),
    .past_end(pe_c), .prog_len(pl_c), .loading(ld_c), .full(fu_c), .overflow(ov_c));

  logic [31:0] prog_a [10] = '{32'h200101A7, 32'h20020005, 32'h00221820, 32'h00611022,
                               32'h8C040004, 32'h00852024, 32'h10A00002, 32'h00C73025,
                               32'h08000003, 32'hAC070000};
  logic [31:0] reload_a [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
  logic [31:0] small_w [6]  = '{32'hA0000000, 32'hA1111111, 32'hA2222222,
                                32'hA3333333, 32'hA4444444, 32'hA5555555};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic fetch_a(input logic [5:0] addr);
    fe_a = 1'b1;
    fa_a = addr;
    @(negedge clk);
    fe_a = 1'b0;
  endtask

  initial begin
    li_a = 0; fe_a = 0; ins_a = '0; fa_a = '0;
    li_b = 0; fe_b = 0; ins_b = '0; fa_b = '0;
    li_c = 0; fe_c = 0; ins_c = '0; fa_c = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_fetch_data", fd_a, 32'h0);
    check("rst_fetch_valid", fv_a, 1'b0);
    check("rst_past_end", pe_a, 1'b0);
    check("rst_loading", ld_a, 1'b0);
    check("rst_full", fu_a, 1'b0);
    check("rst_overflow", ov_a, 1'b0);
    check("rst_prog_len_clear", pl_c, 5'd0);
    rst_n = 1'b1;

    // 4-deep store: load 6 words, last two dropped
    li_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ins_b = small_w[i];
      @(negedge clk);
      if (i == 0) check("b_loading", ld_b, 1'b1);
      if (i == 2) check("b_full_after3", fu_b, 1'b0);
      if (i == 3) begin
        check("b_full_after4", fu_b, 1'b1);
        check("b_ovf_after4", ov_b, 1'b0);
      end
      if (i == 4) check("b_ovf_after5", ov_b, 1'b1);
    end
    li_b = 1'b0;
    @(negedge clk);
    check("b_prog_len", pl_b, 3'd4);
    check("b_loading_off", ld_b, 1'b0);
    check("b_full_hold", fu_b, 1'b1);
    check("b_ovf_sticky", ov_b, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fe_b = 1'b1;
      fa_b = 2'(i);
      @(negedge clk);
      check($sformatf("b_word%0d", i), fd_b, small_w[i]);
      check($sformatf("b_valid%0d", i), fv_b, 1'b1);
      check($sformatf("b_past%0d", i), pe_b, 1'b0);
    end
    fe_b = 1'b0;

    // Clearing store: load 3 words
    li_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins_c = small_w[i];
      @(negedge clk);
    end
    li_c = 1'b0;
    @(negedge clk);
    check("c_prog_len", pl_c, 5'd3);
    check("c_loading", ld_c, 1'b0);
    check("c_full", fu_c, 1'b0);
    check("c_overflow", ov_c, 1'b0);
    fe_c = 1'b1;
    fa_c = 4'd1;
    @(negedge clk);
    fe_c = 1'b0;
    check("c_word1", fd_c, small_w[1]);

    // Load 10-word program, fetch inside and past the end
    li_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ins_a = prog_a[i];
      @(negedge clk);
      if (i == 0) check("a_loading", ld_a, 1'b1);
    end
    li_a = 1'b0;
    @(negedge clk);
    check("a_prog_len", pl_a, 7'd10);
    check("a_loading_off", ld_a, 1'b0);
    fetch_a(6'd0);
    check("a_fetch0_data", fd_a, 32'h200101A7);
    check("a_fetch0_valid", fv_a, 1'b1);
    check("a_fetch0_past", pe_a, 1'b0);
    fetch_a(6'd9);
    check("a_fetch9_data", fd_a, 32'hAC070000);
    fetch_a(6'd10);
    check("a_fetch10_data", fd_a, 32'h0);
    check("a_fetch10_past", pe_a, 1'b1);
    check("a_fetch10_valid", fv_a, 1'b1);
    @(negedge clk);
    check("a_idle_valid", fv_a, 1'b0);
    check("a_idle_past_hold", pe_a, 1'b1);

    // One-cycle reset pulse
    rst_n = 1'b0;
    #1;
    check("a_async_valid", fv_a, 1'b0);
    check("a_async_past", pe_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("a_len_kept", pl_a, 7'd10);
    check("c_len_cleared", pl_c, 5'd0);
    fetch_a(6'd5);
    check("a_after_rst_word5", fd_a, 32'h00852024);
    check("a_after_rst_valid", fv_a, 1'b1);
    fe_c = 1'b1;
    fa_c = 4'd0;
    @(negedge clk);
    fe_c = 1'b0;
    check("c_after_rst_past", pe_c, 1'b1);
    check("c_after_rst_data", fd_c, 32'h0);
    check("c_after_rst_valid", fv_c, 1'b1);

    // Reset during the third word of a reload
    li_a = 1'b1;
    ins_a = reload_a[0];
    @(negedge clk);
    ins_a = reload_a[1];
    @(negedge clk);
    ins_a = reload_a[2];
    #2;
    rst_n = 1'b0;
    li_a = 1'b0;
    #1;
    check("a_abort_loading", ld_a, 1'b0);
    check("a_abort_wr_ptr", u_dut_a.wr_ptr_reg, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("a_abort_len", pl_a, 7'd10);
    fetch_a(6'd0);
    check("a_abort_word0", fd_a, 32'h11111111);
    fetch_a(6'd1);
    check("a_abort_word1", fd_a, 32'h22222222);
    fetch_a(6'd2);
    check("a_abort_word2_old", fd_a, 32'h00221820);

    // Fetch colliding with load start, then a 2-word program
    li_a = 1'b1;
    ins_a = 32'hCAFE0001;
    fe_a = 1'b1;
    fa_a = 6'd2;
    @(negedge clk);
    fe_a = 1'b0;
    check("a_coll_valid", fv_a, 1'b0);
    check("a_coll_data", fd_a, 32'h0);
    check("a_coll_loading", ld_a, 1'b1);
    ins_a = 32'hCAFE0002;
    @(negedge clk);
    li_a = 1'b0;
    @(negedge clk);
    check("a_len2", pl_a, 7'd2);
    fetch_a(6'd1);
    check("a_len2_word1", fd_a, 32'hCAFE0002);
    fetch_a(6'd2);
    check("a_len2_past", pe_a, 1'b1);
    check("a_len2_nop", fd_a, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
